// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: recovers DATA_BITS-N-1 frames, LSB first, from a 2-flop synchronized line.
// rx_done / frame_err are registered one-cycle strobes; rx_busy reflects the FSM state.
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 b_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t                state_q, state_d;
  logic                  rx_meta_q, rx_s_q;
  logic [TW-1:0]         tick_q, tick_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  done_q, done_d;
  logic                  ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // b_tick in the transition cycle is deliberately not counted
        if (!rx_s_q) begin
          state_d = S_START;
          tick_d  = '0;
        end
      end
      S_START: begin
        if (b_tick) begin
          if (tick_q == HALF_LAST) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      S_DATA: begin
        if (b_tick) begin
          if (tick_q == TICK_LAST) begin
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            tick_d  = '0;
            if (bit_q == BIT_LAST) state_d = S_STOP;
            else                   bit_d   = bit_q + BW'(1);
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      S_STOP: begin
        if (b_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (rx_s_q) begin
              data_d  = shift_q;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      S_BREAK: begin
        // a held-low line must return high before a new start is accepted
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_data   = data_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != S_IDLE);

endmodule
